// File: rtl/sterownik_wtrysku_zaplonu_pkg.sv
// Shared types and constants for the two-cylinder injection/ignition sequencer.
// Angles are in degrees; thresholds are in position-counter ticks.
package sterownik_wtrysku_zaplonu_pkg;

  localparam int KATY_CYKLU = 720;
  localparam int SZER_POZ   = 29;
  localparam int SZER_KATA  = 10;

  typedef enum logic [2:0] {
    BEZCZYNNY = 3'd0,
    GOTOWY    = 3'd1,
    WTRYSK    = 3'd2,
    PRZERWA   = 3'd3,
    LADOWANIE = 3'd4,
    KONIEC    = 3'd5
  } stan_t;

  typedef struct packed {
    logic [SZER_POZ-1:0] tws;
    logic [SZER_POZ-1:0] twk;
    logic [SZER_POZ-1:0] tls;
    logic [SZER_POZ-1:0] tz;
    logic                bez_wtrysku;
  } progi_t;

  // 11-bit angle times 9-bit ticks-per-degree, widened to the position width.
  function automatic logic [SZER_POZ-1:0] na_takty(input logic [SZER_KATA:0] kat,
                                                   input logic [8:0]          tns);
    logic [19:0] iloczyn;
    iloczyn = 20'(kat) * 20'(tns);
    return SZER_POZ'(iloczyn);
  endfunction

endpackage

// File: rtl/sterownik_wtrysku_zaplonu_kanal_cylindra.sv
// One cylinder sequencing channel: injection pulse, coil dwell and spark strobe
// driven from the cylinder's own tick position, with thresholds latched per cycle.
module kanal_cylindra
  import sterownik_wtrysku_zaplonu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                zmiana_rpm,
  input  logic [SZER_POZ-1:0] poz,
  input  logic [3:0]          licznik_cykli,
  input  progi_t              progi,
  input  logic                konfiguracja_ok,
  output logic                wtrysk,
  output logic                cewka,
  output logic                iskra,
  output logic                blad_sync,
  output stan_t               stan
);

  stan_t               stan_n;
  progi_t              progi_q;
  logic [SZER_POZ-1:0] poz_poprz;
  logic                zawiniecie;
  logic                zatrzask;
  logic                wtrysk_n, cewka_n, iskra_n, blad_n;

  assign zawiniecie = (poz == '0) && (poz_poprz != '0);

  always_comb begin
    stan_n   = stan;
    zatrzask = 1'b0;
    wtrysk_n = 1'b0;
    cewka_n  = 1'b0;
    iskra_n  = 1'b0;
    blad_n   = 1'b0;
    if (zmiana_rpm) begin
      stan_n = BEZCZYNNY;
    end else if (stan == BEZCZYNNY) begin
      // The cycle counter leaves zero only after a full sync cycle has elapsed.
      if ((licznik_cykli != '0) && (poz == '0) && konfiguracja_ok) begin
        stan_n   = GOTOWY;
        zatrzask = 1'b1;
      end
    end else if (zawiniecie) begin
      // A wrap before the spark aborts the sequence; no late spark is issued.
      blad_n = (stan inside {WTRYSK, PRZERWA, LADOWANIE});
      if (konfiguracja_ok) begin
        stan_n   = GOTOWY;
        zatrzask = 1'b1;
      end else begin
        stan_n = KONIEC;
      end
    end else begin
      case (stan)
        GOTOWY: begin
          if (poz >= progi_q.tws) begin
            if (progi_q.bez_wtrysku) begin
              stan_n = PRZERWA;
            end else begin
              stan_n   = WTRYSK;
              wtrysk_n = 1'b1;
            end
          end
        end
        WTRYSK: begin
          if (poz >= progi_q.twk) stan_n = PRZERWA;
          else                    wtrysk_n = 1'b1;
        end
        PRZERWA: begin
          if (poz >= progi_q.tls) begin
            stan_n  = LADOWANIE;
            cewka_n = 1'b1;
          end
        end
        LADOWANIE: begin
          if (poz >= progi_q.tz) begin
            stan_n  = KONIEC;
            iskra_n = 1'b1;
          end else begin
            cewka_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stan      <= BEZCZYNNY;
      progi_q   <= '0;
      poz_poprz <= '0;
      wtrysk    <= 1'b0;
      cewka     <= 1'b0;
      iskra     <= 1'b0;
      blad_sync <= 1'b0;
    end else begin
      stan      <= stan_n;
      poz_poprz <= poz;
      if (zatrzask) progi_q <= progi;
      wtrysk    <= wtrysk_n;
      cewka     <= cewka_n;
      iskra     <= iskra_n;
      blad_sync <= blad_n;
    end
  end

endmodule

// File: rtl/sterownik_wtrysku_zaplonu.sv
// Two-cylinder injection/ignition controller: registers shared tick thresholds
// and the configuration check, then runs one sequencing channel per cylinder.
module sterownik_wtrysku_zaplonu
  import sterownik_wtrysku_zaplonu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sygnal_zmiany_rpm,
  input  logic [8:0]           taktowanie_na_stopien,
  input  logic [SZER_POZ-1:0]  licznik_co_tysiac_taktow,
  input  logic [SZER_POZ-1:0]  licznik_co_tysiac_taktow_cylinder_2,
  input  logic [3:0]           zliczanie_obrotow,
  input  logic [3:0]           zliczanie_obrotow_cylinder_2,
  input  logic [SZER_KATA-1:0] kat_wtrysku,
  input  logic [SZER_KATA-1:0] dlugosc_wtrysku,
  input  logic [SZER_KATA-1:0] kat_zaplonu,
  input  logic [SZER_KATA-1:0] dlugosc_ladowania,
  output logic                 wtrysk_1,
  output logic                 wtrysk_2,
  output logic                 cewka_1,
  output logic                 cewka_2,
  output logic                 iskra_1,
  output logic                 iskra_2,
  output logic                 blad_konfiguracji,
  output logic                 blad_synchronizacji,
  output stan_t                stan_kanalu_1,
  output stan_t                stan_kanalu_2
);

  logic [SZER_KATA:0] koniec_wtrysku;
  logic [SZER_KATA:0] poczatek_ladowania;
  logic               konf_zla;
  logic               konf_zaladowana;
  logic               konf_ok;
  logic               blad_sync_1, blad_sync_2;
  progi_t             progi_n, progi_q;

  always_comb begin
    koniec_wtrysku     = {1'b0, kat_wtrysku} + {1'b0, dlugosc_wtrysku};
    poczatek_ladowania = {1'b0, kat_zaplonu} - {1'b0, dlugosc_ladowania};
    // Dwell longer than the spark angle underflows the start; it is rejected here anyway.
    konf_zla = (kat_zaplonu >= SZER_KATA'(KATY_CYKLU)) ||
               (dlugosc_ladowania == '0) ||
               (dlugosc_ladowania > kat_zaplonu) ||
               (koniec_wtrysku > poczatek_ladowania);
    progi_n.tws         = na_takty({1'b0, kat_wtrysku}, taktowanie_na_stopien);
    progi_n.twk         = na_takty(koniec_wtrysku, taktowanie_na_stopien);
    progi_n.tls         = na_takty(poczatek_ladowania, taktowanie_na_stopien);
    progi_n.tz          = na_takty({1'b0, kat_zaplonu}, taktowanie_na_stopien);
    progi_n.bez_wtrysku = (dlugosc_wtrysku == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      progi_q           <= '0;
      blad_konfiguracji <= 1'b0;
      konf_zaladowana   <= 1'b0;
    end else begin
      progi_q           <= progi_n;
      blad_konfiguracji <= konf_zla;
      konf_zaladowana   <= 1'b1;
    end
  end

  // Channels must not latch the reset-zero thresholds before the first real ones exist.
  assign konf_ok = konf_zaladowana && !blad_konfiguracji;

  kanal_cylindra u_kanal_1 (
    .clk             (clk),
    .reset           (reset),
    .zmiana_rpm      (sygnal_zmiany_rpm),
    .poz             (licznik_co_tysiac_taktow),
    .licznik_cykli   (zliczanie_obrotow),
    .progi           (progi_q),
    .konfiguracja_ok (konf_ok),
    .wtrysk          (wtrysk_1),
    .cewka           (cewka_1),
    .iskra           (iskra_1),
    .blad_sync       (blad_sync_1),
    .stan            (stan_kanalu_1)
  );

  kanal_cylindra u_kanal_2 (
    .clk             (clk),
    .reset           (reset),
    .zmiana_rpm      (sygnal_zmiany_rpm),
    .poz             (licznik_co_tysiac_taktow_cylinder_2),
    .licznik_cykli   (zliczanie_obrotow_cylinder_2),
    .progi           (progi_q),
    .konfiguracja_ok (konf_ok),
    .wtrysk          (wtrysk_2),
    .cewka           (cewka_2),
    .iskra           (iskra_2),
    .blad_sync       (blad_sync_2),
    .stan            (stan_kanalu_2)
  );

  assign blad_synchronizacji = blad_sync_1 | blad_sync_2;

endmodule

// File: tb/tb_sterownik_wtrysku_zaplonu.sv
// Bench for the two-cylinder injection/ignition controller: directed scenarios
// plus randomized cycles, all checked against an event-list reference model.
module tb_sterownik_wtrysku_zaplonu;
  import sterownik_wtrysku_zaplonu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset = 1'b1;
  logic                 sygnal_zmiany_rpm = 1'b0;
  logic [8:0]           taktowanie_na_stopien = '0;
  logic [SZER_POZ-1:0]  licznik_co_tysiac_taktow = '0;
  logic [SZER_POZ-1:0]  licznik_co_tysiac_taktow_cylinder_2 = '0;
  logic [3:0]           zliczanie_obrotow = '0;
  logic [3:0]           zliczanie_obrotow_cylinder_2 = '0;
  logic [9:0]           kat_wtrysku = '0, dlugosc_wtrysku = '0;
  logic [9:0]           kat_zaplonu = '0, dlugosc_ladowania = '0;
  logic                 wtrysk_1, wtrysk_2, cewka_1, cewka_2, iskra_1, iskra_2;
  logic                 blad_konfiguracji, blad_synchronizacji;
  stan_t                stan_kanalu_1, stan_kanalu_2;

  sterownik_wtrysku_zaplonu dut (
    .clk                                 (clk),
    .reset                               (reset),
    .sygnal_zmiany_rpm                   (sygnal_zmiany_rpm),
    .taktowanie_na_stopien               (taktowanie_na_stopien),
    .licznik_co_tysiac_taktow            (licznik_co_tysiac_taktow),
    .licznik_co_tysiac_taktow_cylinder_2 (licznik_co_tysiac_taktow_cylinder_2),
    .zliczanie_obrotow                   (zliczanie_obrotow),
    .zliczanie_obrotow_cylinder_2        (zliczanie_obrotow_cylinder_2),
    .kat_wtrysku                         (kat_wtrysku),
    .dlugosc_wtrysku                     (dlugosc_wtrysku),
    .kat_zaplonu                         (kat_zaplonu),
    .dlugosc_ladowania                   (dlugosc_ladowania),
    .wtrysk_1                            (wtrysk_1),
    .wtrysk_2                            (wtrysk_2),
    .cewka_1                             (cewka_1),
    .cewka_2                             (cewka_2),
    .iskra_1                             (iskra_1),
    .iskra_2                             (iskra_2),
    .blad_konfiguracji                   (blad_konfiguracji),
    .blad_synchronizacji                 (blad_synchronizacji),
    .stan_kanalu_1                       (stan_kanalu_1),
    .stan_kanalu_2                       (stan_kanalu_2)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic sprawdz(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each channel walks an ordered list of four events (injection start/end,
  // dwell start, spark); ph is the index of the next event, -1 idle, 4 done.
  int m_ph[2];
  int m_prev[2];
  int m_thr[2][4];
  bit m_dl0[2];
  int r_thr[4];
  bit r_dl0, r_ok, r_loaded;
  bit e_w[2], e_c[2], e_i[2], e_s, e_b;

  function automatic bit konf_zla(int kw, int dl, int kz, int kl);
    return (kz >= 720) || (kl == 0) || (kl > kz) || ((kw + dl) > (kz - kl));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = -1; m_prev[k] = 0;
      e_w[k] = 0; e_c[k] = 0; e_i[k] = 0;
    end
    r_loaded = 0; r_ok = 0; e_s = 0; e_b = 0;
  endtask

  task automatic model_krok(input int p1, input int p2);
    int p[2];
    int c[2];
    int kw, dl, kz, kl, t;
    bit ok, wrap;
    p[0] = p1; p[1] = p2;
    c[0] = int'(zliczanie_obrotow); c[1] = int'(zliczanie_obrotow_cylinder_2);
    ok  = r_loaded && r_ok;
    e_s = 0;
    for (int k = 0; k < 2; k++) begin
      e_i[k] = 0;
      wrap = (p[k] == 0) && (m_prev[k] != 0);
      if (sygnal_zmiany_rpm) begin
        m_ph[k] = -1;
      end else if (m_ph[k] == -1) begin
        if (c[k] != 0 && p[k] == 0 && ok) begin
          m_ph[k] = 0;
          for (int j = 0; j < 4; j++) m_thr[k][j] = r_thr[j];
          m_dl0[k] = r_dl0;
        end
      end else if (wrap) begin
        if (m_ph[k] >= 1 && m_ph[k] <= 3) e_s = 1;
        if (ok) begin
          m_ph[k] = 0;
          for (int j = 0; j < 4; j++) m_thr[k][j] = r_thr[j];
          m_dl0[k] = r_dl0;
        end else begin
          m_ph[k] = 4;
        end
      end else if (m_ph[k] < 4 && p[k] >= m_thr[k][m_ph[k]]) begin
        if (m_ph[k] == 3) e_i[k] = 1;
        m_ph[k] = (m_ph[k] == 0 && m_dl0[k]) ? 2 : m_ph[k] + 1;
      end
      e_w[k] = (m_ph[k] == 1);
      e_c[k] = (m_ph[k] == 3);
      m_prev[k] = p[k];
    end
    t  = int'(taktowanie_na_stopien);
    kw = int'(kat_wtrysku); dl = int'(dlugosc_wtrysku);
    kz = int'(kat_zaplonu); kl = int'(dlugosc_ladowania);
    r_thr[0] = kw * t;
    r_thr[1] = (kw + dl) * t;
    r_thr[2] = (kz - kl) * t;
    r_thr[3] = kz * t;
    r_dl0    = (dl == 0);
    r_ok     = !konf_zla(kw, dl, kz, kl);
    r_loaded = 1;
    e_b      = !r_ok;
  endtask

  // ---------------- observation tracking for directed checks ----------------
  bit sledz = 0;
  int pierwszy_w[2], ostatni_w[2], pierwszy_c[2], ostatni_c[2];
  int poz_iskry[2], liczba_iskier[2], akt[2];

  task automatic sledz_start();
    for (int k = 0; k < 2; k++) begin
      pierwszy_w[k] = -1; ostatni_w[k] = -1; pierwszy_c[k] = -1; ostatni_c[k] = -1;
      poz_iskry[k] = -1; liczba_iskier[k] = 0; akt[k] = 0;
    end
    sledz = 1;
  endtask

  // ---------------- drivers ----------------
  task automatic ustaw_konf(input int t, input int kw, input int dl, input int kz, input int kl);
    taktowanie_na_stopien = 9'(t);
    kat_wtrysku       = 10'(kw);
    dlugosc_wtrysku   = 10'(dl);
    kat_zaplonu       = 10'(kz);
    dlugosc_ladowania = 10'(kl);
  endtask

  task automatic krok(input int p1, input int p2);
    logic [7:0] obs, exp;
    bit w[2], c[2], i[2];
    int pp[2];
    licznik_co_tysiac_taktow            = SZER_POZ'(p1);
    licznik_co_tysiac_taktow_cylinder_2 = SZER_POZ'(p2);
    @(posedge clk);
    model_krok(p1, p2);
    #1;
    obs = {wtrysk_1, wtrysk_2, cewka_1, cewka_2, iskra_1, iskra_2,
           blad_konfiguracji, blad_synchronizacji};
    exp = {e_w[0], e_w[1], e_c[0], e_c[1], e_i[0], e_i[1], e_b, e_s};
    sprawdz("wyjscia", obs, exp);
    if (sledz) begin
      w[0] = wtrysk_1; w[1] = wtrysk_2; c[0] = cewka_1; c[1] = cewka_2;
      i[0] = iskra_1;  i[1] = iskra_2;  pp[0] = p1;     pp[1] = p2;
      for (int k = 0; k < 2; k++) begin
        if (w[k] && pierwszy_w[k] < 0) pierwszy_w[k] = pp[k];
        if (w[k]) ostatni_w[k] = pp[k];
        if (c[k] && pierwszy_c[k] < 0) pierwszy_c[k] = pp[k];
        if (c[k]) ostatni_c[k] = pp[k];
        if (i[k]) begin poz_iskry[k] = pp[k]; liczba_iskier[k]++; end
        if (w[k] || c[k] || i[k]) akt[k]++;
      end
    end
  endtask

  // Cylinder 1 ramps od..koniec; cylinder 2 trails it by 360 degrees (720 ticks at 1 tick/step).
  task automatic obieg(input int od, input int koniec, input int max_krok, input bit los_rpm);
    int p, s;
    p = od;
    while (1) begin
      sygnal_zmiany_rpm = los_rpm && ($urandom_range(0, 499) == 0);
      krok(p, (p >= 720) ? p - 720 : p + 720);
      sygnal_zmiany_rpm = 1'b0;
      if (p >= koniec) break;
      s = $urandom_range(1, max_krok);
      if (p < 720 && p + s > 720) s = 720 - p;
      if (p + s > koniec) s = koniec - p;
      p += s;
    end
  endtask

  task automatic losuj_konf();
    int t, kz, kl, kw, dl, luz;
    t   = $urandom_range(1, 3);
    kz  = $urandom_range(20, 719);
    kl  = $urandom_range(1, (kz < 200) ? kz : 200);
    luz = kz - kl;
    kw  = $urandom_range(0, luz);
    dl  = $urandom_range(0, luz - kw);
    if ($urandom_range(0, 5) == 0) kz = 720 + $urandom_range(0, 100);
    ustaw_konf(t, kw, dl, kz, kl);
  endtask

  task automatic sprawdz_reset(input string tag);
    sprawdz(tag, {wtrysk_1, wtrysk_2, cewka_1, cewka_2, iskra_1, iskra_2,
                  blad_konfiguracji, blad_synchronizacji}, 8'h00);
    sprawdz({tag, "_stan"}, {stan_kanalu_1, stan_kanalu_2}, {BEZCZYNNY, BEZCZYNNY});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ustaw_konf(2, 10, 20, 340, 30);
    zliczanie_obrotow = 4'd1;
    zliczanie_obrotow_cylinder_2 = 4'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sprawdz_reset("reset");
    reset = 1'b0;
    model_reset();

    // Basic cycle on cylinder 1, cylinder 2 held in sync wait (count 0).
    repeat (3) krok(0, 720);
    sledz_start();
    obieg(1, 1439, 1, 0);
    sprawdz("c1_wtrysk_start", pierwszy_w[0], 20);
    sprawdz("c1_wtrysk_stop", ostatni_w[0], 59);
    sprawdz("c1_cewka_start", pierwszy_c[0], 620);
    sprawdz("c1_cewka_stop", ostatni_c[0], 679);
    sprawdz("c1_iskra_poz", poz_iskry[0], 680);
    sprawdz("c1_iskra_ile", liczba_iskier[0], 1);
    sprawdz("c2_cisza", akt[1], 0);

    // Cylinder 2 joins at its own wrap.
    zliczanie_obrotow_cylinder_2 = 4'd1;
    sledz_start();
    obieg(0, 1439, 1, 0);
    sprawdz("c2_wtrysk_start", pierwszy_w[1], 20);
    sprawdz("c2_wtrysk_stop", ostatni_w[1], 59);
    sprawdz("c2_cewka_start", pierwszy_c[1], 620);
    sprawdz("c2_cewka_stop", ostatni_c[1], 679);
    sprawdz("c2_iskra_poz", poz_iskry[1], 680);

    // Invalid spark angle: error flag next clock, cylinder 1 silent next cycle.
    obieg(0, 1429, 1, 0);
    kat_zaplonu = 10'd720;
    krok(1430, 710);
    sprawdz("blad_konf", blad_konfiguracji, 1);
    obieg(1431, 1439, 1, 0);
    sledz_start();
    obieg(0, 1437, 2, 0);
    sprawdz("c1_cisza_blad", akt[0], 0);

    // Wrap during dwell (Tz = 800 ticks).
    ustaw_konf(2, 10, 20, 400, 100);
    obieg(1438, 1439, 1, 0);
    obieg(0, 700, 1, 0);
    sprawdz("cewka_przed_wrap", cewka_1, 1);
    krok(0, 720);
    sprawdz("wrap_ladowanie", {blad_synchronizacji, cewka_1, iskra_1}, 3'b100);
    krok(1, 721);
    sprawdz("sync_jeden_takt", blad_synchronizacji, 0);

    // RPM change during injection.
    obieg(2, 30, 1, 0);
    sprawdz("wtrysk_przed_rpm", wtrysk_1, 1);
    sygnal_zmiany_rpm = 1'b1;
    krok(31, 751);
    sygnal_zmiany_rpm = 1'b0;
    sprawdz("po_rpm", {wtrysk_1, cewka_1, iskra_1, wtrysk_2, cewka_2, iskra_2}, 6'b0);
    sledz_start();
    obieg(32, 1437, 3, 0);
    sprawdz("c1_cisza_rpm", akt[0], 0);

    // Zero-length injection.
    ustaw_konf(2, 10, 0, 340, 30);
    obieg(1438, 1439, 1, 0);
    sledz_start();
    obieg(0, 1439, 1, 0);
    sprawdz("bez_wtrysku", pierwszy_w[0], -1);
    sprawdz("bez_wtrysku_cewka", pierwszy_c[0], 620);
    sprawdz("bez_wtrysku_cewka_stop", ostatni_c[0], 679);
    sprawdz("bez_wtrysku_iskra", poz_iskry[0], 680);
    sledz = 0;

    // Randomized cycles: configs, counts, step sizes and occasional RPM pulses.
    for (int n = 0; n < 8; n++) begin
      zliczanie_obrotow            = 4'($urandom_range(0, 3));
      zliczanie_obrotow_cylinder_2 = 4'($urandom_range(0, 3));
      obieg(0, 1437, 3, 1);
      losuj_konf();
      obieg(1438, 1439, 1, 0);
    end

    // Reset mid-sequence dominates a simultaneous RPM change.
    ustaw_konf(2, 10, 20, 340, 30);
    zliczanie_obrotow = 4'd1;
    zliczanie_obrotow_cylinder_2 = 4'd1;
    obieg(0, 1439, 2, 0);
    obieg(0, 30, 1, 0);
    reset = 1'b1;
    sygnal_zmiany_rpm = 1'b1;
    @(posedge clk);
    #1;
    sprawdz_reset("reset_w_locie");
    reset = 1'b0;
    sygnal_zmiany_rpm = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sterownik_wtrysku_zaplonu.md
# sterownik_wtrysku_zaplonu

Downstream consumer of the two-cylinder angle counters (per-cylinder 1000-clock tick position over a 720° cycle plus cycle counters). Converts configured crank angles into tick thresholds and drives injector pulses, coil dwell levels and spark strobes for cylinders 1 and 2. Each cylinder runs an independent sequencing channel on its own position counter, so cylinder 2 fires 360° after cylinder 1.

## Interface
- KATY_CYKLU, 720, degrees per engine cycle
- SZER_POZ, 29, width of position counters

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sygnal_zmiany_rpm  in  1  RPM change; resynchronise both channels
- taktowanie_na_stopien  in  9  ticks per degree
- licznik_co_tysiac_taktow  in  SZER_POZ  cylinder 1 position, ticks
- licznik_co_tysiac_taktow_cylinder_2  in  SZER_POZ  cylinder 2 position, ticks
- zliczanie_obrotow  in  4  cylinder 1 completed-cycle count
- zliczanie_obrotow_cylinder_2  in  4  cylinder 2 completed-cycle count
- kat_wtrysku  in  10  injection start, degrees
- dlugosc_wtrysku  in  10  injection length, degrees
- kat_zaplonu  in  10  spark angle, degrees
- dlugosc_ladowania  in  10  coil dwell before spark, degrees
- wtrysk_1, wtrysk_2  out  1  injector drive
- cewka_1, cewka_2  out  1  coil charge
- iskra_1, iskra_2  out  1  one-clock spark strobe
- blad_konfiguracji  out  1  current angle set invalid
- blad_synchronizacji  out  1  one-clock strobe: cycle wrapped mid-sequence

## Operation
- Thresholds (registered, shared): Tws = kat_wtrysku·tns, Twk = (kat_wtrysku+dlugosc_wtrysku)·tns, Tls = (kat_zaplonu−dlugosc_ladowania)·tns, Tz = kat_zaplonu·tns; tns = taktowanie_na_stopien; 11-bit angle × 9-bit → 20-bit product, zero-extended to SZER_POZ.
- blad_konfiguracji = 1 when kat_zaplonu ≥ KATY_CYKLU, dlugosc_ladowania = 0, dlugosc_ladowania > kat_zaplonu, or kat_wtrysku+dlugosc_wtrysku > kat_zaplonu−dlugosc_ladowania.
- Wrap = position == 0 while previous-clock position ≠ 0.
- Channel FSM (pos = own counter, thresholds latched at entry to GOTOWY):
  - BEZCZYNNY: own cycle count ≠ 0 and pos == 0 and config valid → GOTOWY. First 720° after start/resync is a sync cycle: no outputs.
  - GOTOWY: pos ≥ Tws → WTRYSK (wtrysk=1); if dlugosc_wtrysku == 0 → PRZERWA directly, no pulse.
  - WTRYSK: pos ≥ Twk → PRZERWA (wtrysk=0).
  - PRZERWA: pos ≥ Tls → LADOWANIE (cewka=1).
  - LADOWANIE: pos ≥ Tz → KONIEC; cewka=0, iskra=1 for exactly one clock.
  - KONIEC: wrap → GOTOWY if config valid, else stay KONIEC (cycle skipped, outputs low).
  - Wrap in WTRYSK/PRZERWA/LADOWANIE: outputs low, blad_synchronizacji strobe, → GOTOWY (relatch); no spark issued.
- Config changes mid-cycle take effect only at next latch.
- sygnal_zmiany_rpm = 1: both channels → BEZCZYNNY, all channel outputs 0.
- Both channels events on same clock: independent, both honoured; blad_synchronizacji = OR of channel strobes.

## Timing
- Reset values: all outputs 0, channels BEZCZYNNY, thresholds 0.
- Threshold/blad_konfiguracji latency: 1 clock after input change.
- Output latency: 1 clock after pos satisfies comparison.
- iskra high one clock, coincident with cewka falling.
- sygnal_zmiany_rpm / reset: outputs 0 on next clock; reset dominates.

## Structure
- Shared package: state encodings (BEZCZYNNY..KONIEC), KATY_CYKLU, SZER_POZ, angle width 10.
- Sub-module kanal_cylindra: one FSM + comparators + latched thresholds; instantiated twice. Top holds multipliers and config check.

## Test plan
- tns=2, wtr 10/20, zap 340, lad 30; count=1, ramp cylinder 1 pos 0→1439 → wtrysk_1 high pos 20..59, cewka_1 high 620..679, iskra_1 one clock after pos=680.
- Same config, cylinder 2 counts=0 → no cylinder-2 outputs; set count=1 and wrap → cylinder 2 sequence identical on its counter.
- kat_zaplonu=720 → blad_konfiguracji=1 next clock; outputs stay 0 through next wrap.
- Drive pos 0→700 then wrap to 0 during LADOWANIE (Tz=800, tns=... via config) → cewka drops, blad_synchronizacji one clock, iskra stays 0.
- sygnal_zmiany_rpm pulse during WTRYSK → wtrysk=0 next clock; no outputs until count ≠ 0 and pos wrap.
- dlugosc_wtrysku=0 → wtrysk never rises; coil/spark unaffected.
